// File: rtl/stopwatch_bcd_if.sv
// Control and display bundle between the tick divider, the stopwatch and the
// seven-segment decoder stage.
interface stopwatch_bcd_if;
    logic        tick;
    logic        start_stop;
    logic        lap;
    logic        clear;
    logic [15:0] disp;
    logic        running;
    logic        lapped;
    logic        ovf;

    modport master (
        output tick,
        output start_stop,
        output lap,
        output clear,
        input  disp,
        input  running,
        input  lapped,
        input  ovf
    );

    modport slave (
        input  tick,
        input  start_stop,
        input  lap,
        input  clear,
        output disp,
        output running,
        output lapped,
        output ovf
    );
endinterface

// File: rtl/stopwatch_bcd.sv
// Four-digit BCD MM:SS stopwatch with run/pause/lap control, advanced only by
// the one-second tick pulse. All outputs are registered.
module stopwatch_bcd #(
    parameter int unsigned MIN_WRAP = 60
) (
    input  logic           clk,
    input  logic           rst,
    stopwatch_bcd_if.slave bus
);

    localparam int unsigned MaxMin = MIN_WRAP - 1;
    localparam logic [3:0]  MaxMt  = 4'(MaxMin / 10);
    localparam logic [3:0]  MaxMo  = 4'(MaxMin % 10);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StPause,
        StLap
    } state_e;

    state_e      state_q, state_d;
    logic [3:0]  mt_q, mo_q, st_q, so_q;
    logic [3:0]  mt_d, mo_d, st_d, so_d;
    logic [15:0] lap_q, lap_d;
    logic [15:0] disp_q, disp_d;
    logic        running_q, running_d;
    logic        lapped_q, lapped_d;
    logic        ovf_q, ovf_d;
    logic        count_en;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= StIdle;
            mt_q      <= 4'd0;
            mo_q      <= 4'd0;
            st_q      <= 4'd0;
            so_q      <= 4'd0;
            lap_q     <= 16'h0000;
            disp_q    <= 16'h0000;
            running_q <= 1'b0;
            lapped_q  <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            mt_q      <= mt_d;
            mo_q      <= mo_d;
            st_q      <= st_d;
            so_q      <= so_d;
            lap_q     <= lap_d;
            disp_q    <= disp_d;
            running_q <= running_d;
            lapped_q  <= lapped_d;
            ovf_q     <= ovf_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        mt_d     = mt_q;
        mo_d     = mo_q;
        st_d     = st_q;
        so_d     = so_q;
        lap_d    = lap_q;
        ovf_d    = 1'b0;
        // Tick is judged against the pre-transition state.
        count_en = bus.tick && ((state_q == StRun) || (state_q == StLap));

        if (count_en) begin
            if (so_q == 4'd9) begin
                so_d = 4'd0;
                if (st_q == 4'd5) begin
                    st_d = 4'd0;
                    if ((mt_q == MaxMt) && (mo_q == MaxMo)) begin
                        mt_d  = 4'd0;
                        mo_d  = 4'd0;
                        ovf_d = 1'b1;
                    end else if (mo_q == 4'd9) begin
                        mo_d = 4'd0;
                        mt_d = mt_q + 4'd1;
                    end else begin
                        mo_d = mo_q + 4'd1;
                    end
                end else begin
                    st_d = st_q + 4'd1;
                end
            end else begin
                so_d = so_q + 4'd1;
            end
        end

        if (bus.clear) begin
            state_d = StIdle;
            mt_d    = 4'd0;
            mo_d    = 4'd0;
            st_d    = 4'd0;
            so_d    = 4'd0;
            lap_d   = 16'h0000;
            ovf_d   = 1'b0;
        end else if (bus.start_stop) begin
            unique case (state_q)
                StIdle:  state_d = StRun;
                StRun:   state_d = StPause;
                StPause: state_d = StRun;
                StLap:   state_d = StPause;
                default: state_d = StIdle;
            endcase
        end else if (bus.lap) begin
            unique case (state_q)
                StRun: begin
                    state_d = StLap;
                    lap_d   = {mt_q, mo_q, st_q, so_q};
                end
                StLap:   state_d = StRun;
                default: state_d = state_q;
            endcase
        end

        disp_d    = (state_d == StLap) ? lap_d : {mt_d, mo_d, st_d, so_d};
        running_d = (state_d == StRun) || (state_d == StLap);
        lapped_d  = (state_d == StLap);
    end

    assign bus.disp    = disp_q;
    assign bus.running = running_q;
    assign bus.lapped  = lapped_q;
    assign bus.ovf     = ovf_q;

endmodule

// File: tb/tb_stopwatch_bcd.sv
// Directed bench for stopwatch_bcd: a vector table for single-cycle control
// behaviour plus hand sequences for long counts, wrap and reset.
module tb_stopwatch_bcd;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    stopwatch_bcd_if sw ();
    stopwatch_bcd_if sw10 ();

    stopwatch_bcd #(.MIN_WRAP(60)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (sw.slave)
    );

    stopwatch_bcd #(.MIN_WRAP(10)) u_dut10 (
        .clk (clk),
        .rst (rst),
        .bus (sw10.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        tick;
        logic        ss;
        logic        lp;
        logic        clr;
        logic [15:0] disp;
        logic        run;
        logic        lapd;
        logic        ovf;
        string       name;
    } vec_t;

    vec_t vecs [17];

    task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic check_all(input string name, input logic [15:0] d, input logic r,
                             input logic l, input logic o);
        check16({name, ".disp"}, sw.disp, d);
        check1({name, ".running"}, sw.running, r);
        check1({name, ".lapped"}, sw.lapped, l);
        check1({name, ".ovf"}, sw.ovf, o);
    endtask

    // Drive one cycle of inputs, then sample 1 time unit after the edge.
    task automatic step(input logic t, input logic ss, input logic lp, input logic clr);
        sw.tick       = t;
        sw.start_stop = ss;
        sw.lap        = lp;
        sw.clear      = clr;
        @(posedge clk);
        #1;
        sw.tick       = 1'b0;
        sw.start_stop = 1'b0;
        sw.lap        = 1'b0;
        sw.clear      = 1'b0;
    endtask

    task automatic step10(input logic t, input logic ss);
        sw10.tick       = t;
        sw10.start_stop = ss;
        @(posedge clk);
        #1;
        sw10.tick       = 1'b0;
        sw10.start_stop = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b0;
        sw.tick = 1'b0; sw.start_stop = 1'b0; sw.lap = 1'b0; sw.clear = 1'b0;
        sw10.tick = 1'b0; sw10.start_stop = 1'b0; sw10.lap = 1'b0; sw10.clear = 1'b0;

        //            tick ss   lap  clr   disp      run  lapd ovf
        vecs[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, "idle_quiet"};
        vecs[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, "idle_tick"};
        vecs[2]  = '{1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, "idle_ss_tick"};
        vecs[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 16'h0001, 1'b1, 1'b0, 1'b0, "run_tick1"};
        vecs[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, 16'h0002, 1'b1, 1'b0, 1'b0, "run_tick2"};
        vecs[5]  = '{1'b1, 1'b0, 1'b1, 1'b0, 16'h0002, 1'b1, 1'b1, 1'b0, "lap_cap_tick"};
        vecs[6]  = '{1'b1, 1'b0, 1'b0, 1'b0, 16'h0002, 1'b1, 1'b1, 1'b0, "lap_frozen"};
        vecs[7]  = '{1'b0, 1'b0, 1'b1, 1'b0, 16'h0004, 1'b1, 1'b0, 1'b0, "lap_release"};
        vecs[8]  = '{1'b1, 1'b0, 1'b1, 1'b0, 16'h0004, 1'b1, 1'b1, 1'b0, "lap_again"};
        vecs[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h0005, 1'b0, 1'b0, 1'b0, "lap_to_pause"};
        vecs[10] = '{1'b1, 1'b0, 1'b0, 1'b0, 16'h0005, 1'b0, 1'b0, 1'b0, "pause_tick"};
        vecs[11] = '{1'b0, 1'b0, 1'b1, 1'b0, 16'h0005, 1'b0, 1'b0, 1'b0, "pause_lap_ign"};
        vecs[12] = '{1'b1, 1'b1, 1'b0, 1'b0, 16'h0005, 1'b1, 1'b0, 1'b0, "pause_ss_tick"};
        vecs[13] = '{1'b1, 1'b1, 1'b1, 1'b0, 16'h0006, 1'b0, 1'b0, 1'b0, "run_ss_lap_tick"};
        vecs[14] = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h0006, 1'b1, 1'b0, 1'b0, "resume"};
        vecs[15] = '{1'b1, 1'b1, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, "clear_ss_tick"};
        vecs[16] = '{1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, "idle_tick2"};

        repeat (2) @(posedge clk);
        #1;
        check_all("reset", 16'h0000, 1'b0, 1'b0, 1'b0);
        check16("reset10.disp", sw10.disp, 16'h0000);
        rst = 1'b1;

        for (int i = 0; i < 17; i++) begin
            step(vecs[i].tick, vecs[i].ss, vecs[i].lp, vecs[i].clr);
            check_all(vecs[i].name, vecs[i].disp, vecs[i].run, vecs[i].lapd, vecs[i].ovf);
        end

        // Run 75 s, then pause and resume.
        step(1'b0, 1'b1, 1'b0, 1'b0);
        ticks(75);
        check_all("run75", 16'h0115, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        ticks(10);
        check_all("paused", 16'h0115, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        ticks(5);
        check_all("resumed", 16'h0120, 1'b1, 1'b0, 1'b0);

        // Lap capture with simultaneous tick.
        step(1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        ticks(9);
        check16("at9.disp", sw.disp, 16'h0009);
        step(1'b1, 1'b0, 1'b1, 1'b0);
        check_all("lap9", 16'h0009, 1'b1, 1'b1, 1'b0);
        ticks(3);
        check_all("lap9_hold", 16'h0009, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        check_all("lap_live13", 16'h0013, 1'b1, 1'b0, 1'b0);

        // Full wrap at MIN_WRAP=60.
        step(1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        ticks(3598);
        check_all("at5958", 16'h5958, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        check_all("at5959", 16'h5959, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        check_all("wrap", 16'h0000, 1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        check_all("after_wrap", 16'h0001, 1'b1, 1'b0, 1'b0);

        // Reset while in LAP.
        step(1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        ticks(30);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        check_all("lap30", 16'h0030, 1'b1, 1'b1, 1'b0);
        rst = 1'b0;
        step(1'b1, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        check_all("rst_mid_lap", 16'h0000, 1'b0, 1'b0, 1'b0);
        ticks(3);
        check_all("post_rst_ticks", 16'h0000, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        check_all("post_rst_run", 16'h0001, 1'b1, 1'b0, 1'b0);

        // Wrap at MIN_WRAP=10.
        step10(1'b0, 1'b1);
        for (int i = 0; i < 599; i++) step10(1'b1, 1'b0);
        check16("w10_at0959", sw10.disp, 16'h0959);
        check1("w10_ovf_pre", sw10.ovf, 1'b0);
        step10(1'b1, 1'b0);
        check16("w10_wrap.disp", sw10.disp, 16'h0000);
        check1("w10_wrap.ovf", sw10.ovf, 1'b1);
        check1("w10_wrap.running", sw10.running, 1'b1);
        step10(1'b0, 1'b0);
        check1("w10_ovf_drop", sw10.ovf, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
